// File: rtl/serial_adder_core.sv
// Bit-serial LSB-first adder; a stored carry links consecutive bit positions of a word.
// Latency: 1 cycle when OUT_REG=1, 0 cycles (combinational outputs) when OUT_REG=0.
// Backpressure: none; one bit is consumed on every clk rise while reset is low.
module serial_adder_core #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // ST_FIRST means the next sampled bit is bit 0 of a new word.
    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   carry_q, carry_d;
    logic   ec;
    logic   sm;
    logic   co;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FIRST;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        ec      = (state_q == ST_FIRST) ? cin : carry_q;
        sm      = a ^ b ^ ec;
        co      = (a & b) | (a & ec) | (b & ec);
        carry_d = co;
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic s_q;
            logic cout_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s_q    <= 1'b0;
                    cout_q <= 1'b0;
                end else begin
                    s_q    <= sm;
                    cout_q <= co;
                end
            end

            assign s    = s_q;
            assign cout = cout_q;
        end else begin : g_out_comb
            // Forced low during reset so both variants present cleared outputs.
            assign s    = sm & ~reset;
            assign cout = co & ~reset;
        end
    endgenerate

endmodule

// File: tb/tb_serial_adder_core.sv
// Bench for serial_adder_core: registered and combinational variants driven in lockstep,
// checked against word-level arithmetic through a scoreboard queue.
module tb_serial_adder_core;

    logic clk;
    logic reset;
    logic a;
    logic b;
    logic cin;
    logic s_r, cout_r;
    logic s_c, cout_c;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0]  exp_q[$];
    logic [31:0] obs_s;
    logic        obs_c;
    int          reg_idx;

    serial_adder_core #(.OUT_REG(1'b1)) u_dut_reg (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (s_r),
        .cout (cout_r)
    );

    serial_adder_core #(.OUT_REG(1'b0)) u_dut_comb (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (s_c),
        .cout (cout_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg();
        logic [1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("reg_s[%0d]", reg_idx), {31'b0, s_r}, {31'b0, e[1]});
            check($sformatf("reg_cout[%0d]", reg_idx), {31'b0, cout_r}, {31'b0, e[0]});
            obs_s[reg_idx] = s_r;
            obs_c          = cout_r;
            reg_idx++;
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_reg_s"}, {31'b0, s_r}, 32'd0);
        check({tag, "_reg_cout"}, {31'b0, cout_r}, 32'd0);
        check({tag, "_comb_s"}, {31'b0, s_c}, 32'd0);
        check({tag, "_comb_cout"}, {31'b0, cout_c}, 32'd0);
    endtask

    // Call in the low clk phase with reset already low; returns on the negedge
    // that shows the registered result of the last bit.
    task automatic run_word(input logic [31:0] op_a, input logic [31:0] op_b,
                            input logic ci, input logic ci_rest, input int n,
                            input bit check_total);
        logic [31:0] mask;
        logic [31:0] tot;
        logic [31:0] seen;
        reg_idx = 0;
        obs_s   = '0;
        obs_c   = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check_reg();
            end
            a    = op_a[i];
            b    = op_b[i];
            cin  = (i == 0) ? ci : ci_rest;
            mask = (32'd1 << (i + 1)) - 32'd1;
            tot  = (op_a & mask) + (op_b & mask) + {31'b0, ci};
            exp_q.push_back({tot[i], tot[i+1]});
            #1;
            check($sformatf("comb_s[%0d]", i), {31'b0, s_c}, {31'b0, tot[i]});
            check($sformatf("comb_cout[%0d]", i), {31'b0, cout_c}, {31'b0, tot[i+1]});
        end
        @(negedge clk);
        check_reg();
        if (check_total) begin
            seen = obs_s | ({31'b0, obs_c} << n);
            check("word_total", seen, op_a + op_b + {31'b0, ci});
        end
    endtask

    task automatic reset_between_words();
        reset = 1'b1;
        a     = 1'bx;
        b     = 1'bx;
        cin   = 1'bx;
        #1;
        check_cleared("rst_pulse");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a     = 1'b1;
        b     = 1'b1;
        cin   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_cleared("reset_hold");
        end
        reset = 1'b0;

        // A=15, B=13, cin=1 -> 29
        run_word(32'd15, 32'd13, 1'b1, 1'b0, 4, 1'b1);

        // A=27, B=17, cin=1 -> 45
        reset_between_words();
        run_word(32'd27, 32'd17, 1'b1, 1'b0, 5, 1'b1);

        // cin held high after bit 0 must not leak into later bits
        reset_between_words();
        run_word(32'd0, 32'd0, 1'b1, 1'b1, 4, 1'b1);

        // Mid-word reset after two bits, pulsed between edges
        reset_between_words();
        run_word(32'd15, 32'd13, 1'b1, 1'b0, 2, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_cleared("mid_word");
        reset = 1'b0;
        run_word(32'd15, 32'd13, 1'b1, 1'b0, 4, 1'b1);

        // Word with cin=0 and a long carry ripple
        reset_between_words();
        run_word(32'd255, 32'd1, 1'b0, 1'b1, 8, 1'b1);

        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no end of test expected completion");
        $fatal(1, "timeout");
    end

endmodule
